sync_fifo_prog: RTL

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, occupancy count, synchronous flush and a selectable first-word-fall-through (FWFT) read mode. It is the same-clock-domain counterpart of the async FIFO and serves as rate-matching and elastic buffering between blocks sharing `clk`. The overflow/underflow error reporting matches the async FIFO, so downstream monitors reuse unchanged.

---
 rtl/sync_fifo_prog.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, synchronous flush and a build-time choice
// between a registered read port and first-word-fall-through.
module sync_fifo_prog #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 8,
    parameter int ADDRESS_SIZE    = 4,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter int FWFT            = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    wr_en_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    rd_en_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    valid,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    almost_empty_o,
    output logic                    almost_full_o,
    output logic [ADDRESS_SIZE-1:0] count_o,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDRESS_SIZE-1:0] AF_TH = ADDRESS_SIZE'(ALMOST_FULL_TH);
    localparam logic [ADDRESS_SIZE-1:0] AE_TH = ADDRESS_SIZE'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [ADDRESS_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;

    logic [IDX_W-1:0]        wr_idx, rd_idx;
    logic [ADDRESS_SIZE-1:0] count;
    logic                    empty, full;
    logic                    wr_acc, rd_acc;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];

    // Status decode purely from the registered pointers; full is "same slot,
    // opposite lap", empty is "pointers identical".
    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_idx == rd_idx) &&
                (wr_ptr_q[ADDRESS_SIZE-1] != rd_ptr_q[ADDRESS_SIZE-1]);
    end

    assign count_o        = count;
    assign empty_o        = empty;
    assign full_o         = full;
    assign almost_full_o  = (count >= AF_TH);
    assign almost_empty_o = (count <= AE_TH);
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

    // Accept decisions; flush overrides both sides, no write-to-read bypass.
    assign wr_acc = wr_en_i && !full  && !flush_i;
    assign rd_acc = rd_en_i && !empty && !flush_i;

    // Next pointer and error-pulse values.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = wr_en_i && full  && !flush_i;
        underflow_d = rd_en_i && empty && !flush_i;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and error-pulse registers; reset empties the FIFO at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents survive flush and reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_idx] <= data_i;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally whenever the FIFO holds data.
            always_comb begin
                data_o = '0;
                valid  = 1'b0;
                if (!empty) begin
                    data_o = mem_q[rd_idx];
                    valid  = 1'b1;
                end
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_q, data_d;
            logic                  valid_q, valid_d;

            // Registered read port: load on an accepted read, otherwise hold.
            always_comb begin
                data_d  = data_q;
                valid_d = 1'b0;
                if (flush_i) begin
                    data_d = '0;
                end else if (rd_acc) begin
                    data_d  = mem_q[rd_idx];
                    valid_d = 1'b1;
                end
            end

            // Read data and valid registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign data_o = data_q;
            assign valid  = valid_q;
        end
    endgenerate

endmodule
